// File: rtl/pe_inject_arbiter.sv
// Round-robin arbiter sharing one mesh switch PE injection port among N_REQ requesters.
// Optional statistics counters (o_flit_cnt, o_stall_cnt) are enabled by defining INJ_STATS_EN.
module pe_inject_arbiter #(
    parameter int X           = 2,
    parameter int Y           = 2,
    parameter int data_width  = 32,
    parameter int x_size      = 1,
    parameter int y_size      = 1,
    parameter int N_REQ       = 4,
    parameter int total_width = x_size + y_size + data_width
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            i_req_valid,
    output logic [N_REQ-1:0]            o_req_ready,
    input  logic [N_REQ*data_width-1:0] i_req_data,
    input  logic [N_REQ*x_size-1:0]     i_req_x,
    input  logic [N_REQ*y_size-1:0]     i_req_y,
    output logic                        o_valid_sw,
    output logic [total_width-1:0]      o_data_sw,
    input  logic                        i_ready_sw,
    output logic                        o_err_dest
`ifdef INJ_STATS_EN
    ,
    output logic [31:0]                 o_flit_cnt,
    output logic [31:0]                 o_stall_cnt
`endif
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [PW:0] NREQ_W = (PW + 1)'(N_REQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [total_width-1:0] data_q, data_d;
    logic                   err_q, err_d;
    logic [PW-1:0]          ptr_q, ptr_d;

    logic                   load;
    logic                   found;
    logic [PW:0]            idx_w;
    logic [PW-1:0]          sel;
    logic [N_REQ-1:0]       grant;
    logic [data_width-1:0]  data_sel;
    logic [x_size-1:0]      x_sel;
    logic [y_size-1:0]      y_sel;
    logic                   in_range;

    assign load = (state_q == ST_EMPTY) || i_ready_sw;

    // Rotating priority search starting at the pointer; only the first valid requester wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        grant = '0;
        idx_w = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_w = {1'b0, ptr_q} + (PW + 1)'(i);
            if (idx_w >= NREQ_W) begin
                idx_w = idx_w - NREQ_W;
            end
            if (!found && load && i_req_valid[idx_w[PW-1:0]]) begin
                found = 1'b1;
                sel   = idx_w[PW-1:0];
            end
        end
        if (found) begin
            grant[sel] = 1'b1;
        end
    end

    assign o_req_ready = grant;

    assign data_sel = i_req_data[int'(sel)*data_width +: data_width];
    assign x_sel    = i_req_x[int'(sel)*x_size +: x_size];
    assign y_sel    = i_req_y[int'(sel)*y_size +: y_size];
    assign in_range = (int'(x_sel) < X) && (int'(y_sel) < Y);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = 1'b0;
        ptr_d   = ptr_q;
        if (found) begin
            ptr_d = (sel == LAST_IDX) ? '0 : sel + 1'b1;
            if (in_range) begin
                state_d = ST_FULL;
                data_d  = {data_sel, y_sel, x_sel};
            end else begin
                // A dropped flit still frees the register if it was being transferred.
                state_d = ST_EMPTY;
                err_d   = 1'b1;
            end
        end else if (state_q == ST_FULL && i_ready_sw) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_valid_sw = (state_q == ST_FULL);
    assign o_data_sw  = data_q;
    assign o_err_dest = err_q;

`ifdef INJ_STATS_EN
    logic [31:0] flit_cnt_q, flit_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        flit_cnt_d  = flit_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (o_valid_sw && i_ready_sw) begin
            flit_cnt_d = flit_cnt_q + 32'd1;
        end
        if (o_valid_sw && !i_ready_sw) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flit_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            flit_cnt_q  <= flit_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_flit_cnt  = flit_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Directed self-checking bench for pe_inject_arbiter: default instance plus an x_size=2 instance
// used to exercise out-of-range destination drops.
module tb_pe_inject_arbiter;

    logic         clk;
    logic         rstn;

    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_data;
    logic [3:0]   req_x;
    logic [3:0]   req_y;
    logic         valid_sw;
    logic [33:0]  data_sw;
    logic         ready_sw;
    logic         err_dest;

    logic [3:0]   b_valid;
    logic [3:0]   b_ready;
    logic [127:0] b_data;
    logic [7:0]   b_x;
    logic [3:0]   b_y;
    logic         b_valid_sw;
    logic [34:0]  b_data_sw;
    logic         b_ready_sw;
    logic         b_err;

`ifdef INJ_STATS_EN
    logic [31:0]  flit_cnt, stall_cnt;
    logic [31:0]  b_flit_cnt, b_stall_cnt;
`endif

    int checks_total;
    int checks_passed;

    pe_inject_arbiter dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_data  (req_data),
        .i_req_x     (req_x),
        .i_req_y     (req_y),
        .o_valid_sw  (valid_sw),
        .o_data_sw   (data_sw),
        .i_ready_sw  (ready_sw),
        .o_err_dest  (err_dest)
`ifdef INJ_STATS_EN
        ,
        .o_flit_cnt  (flit_cnt),
        .o_stall_cnt (stall_cnt)
`endif
    );

    pe_inject_arbiter #(.X(2), .Y(2), .x_size(2), .y_size(1)) dut_err (
        .clk         (clk),
        .rstn        (rstn),
        .i_req_valid (b_valid),
        .o_req_ready (b_ready),
        .i_req_data  (b_data),
        .i_req_x     (b_x),
        .i_req_y     (b_y),
        .o_valid_sw  (b_valid_sw),
        .o_data_sw   (b_data_sw),
        .i_ready_sw  (b_ready_sw),
        .o_err_dest  (b_err)
`ifdef INJ_STATS_EN
        ,
        .o_flit_cnt  (b_flit_cnt),
        .o_stall_cnt (b_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected flit for requester k of the default instance, built from the bench's own inputs.
    function automatic logic [33:0] flit_of(input int k);
        return {req_data[k*32 +: 32], req_y[k], req_x[k]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        req_x      = '0;
        req_y      = '0;
        ready_sw   = 1'b0;
        b_valid    = '0;
        b_data     = '0;
        b_x        = '0;
        b_y        = '0;
        b_ready_sw = 1'b1;
        #12;
        checks_total++;
        if (valid_sw !== 1'b0 || data_sw !== 34'd0 || err_dest !== 1'b0 || req_ready !== 4'd0) begin
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h err=%b ready=%b required 0/0/0/0",
                     valid_sw, data_sw, err_dest, req_ready);
        end else checks_passed++;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_valid       = 4'b0001;
        req_x           = 4'b0001;
        req_y           = 4'b0000;
        req_data[31:0]  = 32'hA5A5_A5A5;
        ready_sw        = 1'b1;
        #1;
        checks_total++;
        if (req_ready !== 4'b0001) begin
            $display("[TB] FAIL single_grant: got ready=%b required 0001", req_ready);
        end else checks_passed++;
        tick();
        req_valid = '0;
        checks_total++;
        if (valid_sw !== 1'b1 || data_sw !== 34'h2_9696_9695) begin
            $display("[TB] FAIL single_flit: got valid=%b data=%h required 1 data=296969695",
                     valid_sw, data_sw);
        end else checks_passed++;
        tick();
        checks_total++;
        if (valid_sw !== 1'b0) begin
            $display("[TB] FAIL single_empty: got valid=%b required 0", valid_sw);
        end else checks_passed++;
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_data[k*32 +: 32] = 32'h1000_0000 + 32'(k);
            req_x[k]             = k[0];
            req_y[k]             = k[1];
        end
        ready_sw  = 1'b1;
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks_total++;
            if (req_ready !== (4'b0001 << exp_seq[n])) begin
                $display("[TB] FAIL rr_grant%0d: got ready=%b required req%0d", n, req_ready, exp_seq[n]);
            end else checks_passed++;
            tick();
            checks_total++;
            if (valid_sw !== 1'b1 || data_sw !== flit_of(exp_seq[n])) begin
                $display("[TB] FAIL rr_flit%0d: got valid=%b data=%h required 1 data=%h",
                         n, valid_sw, data_sw, flit_of(exp_seq[n]));
            end else checks_passed++;
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_stall();
        logic [33:0] held;
        req_valid = 4'b0010;
        ready_sw  = 1'b0;
        #1;
        checks_total++;
        if (req_ready !== 4'b0010) begin
            $display("[TB] FAIL stall_grant: got ready=%b required 0010", req_ready);
        end else checks_passed++;
        tick();
        held = flit_of(1);
        for (int n = 0; n < 5; n++) begin
            checks_total++;
            if (valid_sw !== 1'b1 || data_sw !== held || req_ready !== 4'b0000) begin
                $display("[TB] FAIL stall_hold%0d: got valid=%b data=%h ready=%b required 1 %h 0000",
                         n, valid_sw, data_sw, req_ready, held);
            end else checks_passed++;
            tick();
        end
`ifdef INJ_STATS_EN
        checks_total++;
        if (stall_cnt !== 32'd5 || flit_cnt !== 32'd5) begin
            $display("[TB] FAIL stats_counts: got stall=%0d flit=%0d required 5 5", stall_cnt, flit_cnt);
        end else checks_passed++;
`endif
        req_valid = '0;
        ready_sw  = 1'b1;
        tick();
        checks_total++;
        if (valid_sw !== 1'b0) begin
            $display("[TB] FAIL stall_release: got valid=%b required 0", valid_sw);
        end else checks_passed++;
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0100;
        ready_sw  = 1'b0;
        tick();
        req_valid = '0;
        checks_total++;
        if (valid_sw !== 1'b1 || data_sw !== flit_of(2)) begin
            $display("[TB] FAIL mid_full: got valid=%b data=%h required 1 %h", valid_sw, data_sw, flit_of(2));
        end else checks_passed++;
        #2;
        rstn = 1'b0;
        #1;
        checks_total++;
        if (valid_sw !== 1'b0 || data_sw !== 34'd0) begin
            $display("[TB] FAIL mid_async_clear: got valid=%b data=%h required 0 0", valid_sw, data_sw);
        end else checks_passed++;
        req_valid = 4'b1111;
        #1;
        rstn = 1'b1;
        #1;
        checks_total++;
        if (req_ready !== 4'b0001) begin
            $display("[TB] FAIL mid_first_grant: got ready=%b required 0001", req_ready);
        end else checks_passed++;
        tick();
        req_valid = '0;
        ready_sw  = 1'b1;
        checks_total++;
        if (valid_sw !== 1'b1 || data_sw !== flit_of(0)) begin
            $display("[TB] FAIL mid_flit: got valid=%b data=%h required 1 %h", valid_sw, data_sw, flit_of(0));
        end else checks_passed++;
        tick();
    endtask

    task automatic test_only_req3();
        req_valid = 4'b1000;
        ready_sw  = 1'b1;
        #1;
        checks_total++;
        if (req_ready !== 4'b1000) begin
            $display("[TB] FAIL req3_grant: got ready=%b required 1000", req_ready);
        end else checks_passed++;
        tick();
        req_valid = 4'b1111;
        #1;
        checks_total++;
        if (valid_sw !== 1'b1 || data_sw !== flit_of(3) || req_ready !== 4'b0001) begin
            $display("[TB] FAIL req3_wrap: got valid=%b data=%h ready=%b required 1 %h 0001",
                     valid_sw, data_sw, req_ready, flit_of(3));
        end else checks_passed++;
        tick();
        req_valid = '0;
        checks_total++;
        if (valid_sw !== 1'b1 || data_sw !== flit_of(0)) begin
            $display("[TB] FAIL req3_next: got valid=%b data=%h required 1 %h", valid_sw, data_sw, flit_of(0));
        end else checks_passed++;
        tick();
    endtask

    task automatic test_err_dest();
        b_data[64 +: 32] = 32'hDEAD_BEEF;
        b_data[96 +: 32] = 32'h0000_0033;
        b_x[5:4]         = 2'd3;
        b_valid          = 4'b0100;
        #1;
        checks_total++;
        if (b_ready !== 4'b0100) begin
            $display("[TB] FAIL err_grant: got ready=%b required 0100", b_ready);
        end else checks_passed++;
        tick();
        b_valid = '0;
        checks_total++;
        if (b_err !== 1'b1 || b_valid_sw !== 1'b0) begin
            $display("[TB] FAIL err_pulse: got err=%b valid=%b required 1 0", b_err, b_valid_sw);
        end else checks_passed++;
        tick();
        checks_total++;
        if (b_err !== 1'b0 || b_valid_sw !== 1'b0) begin
            $display("[TB] FAIL err_one_cycle: got err=%b valid=%b required 0 0", b_err, b_valid_sw);
        end else checks_passed++;
        b_x     = '0;
        b_valid = 4'b1111;
        #1;
        checks_total++;
        if (b_ready !== 4'b1000) begin
            $display("[TB] FAIL err_ptr3: got ready=%b required 1000", b_ready);
        end else checks_passed++;
        tick();
        b_valid = '0;
        checks_total++;
        if (b_valid_sw !== 1'b1 || b_err !== 1'b0 || b_data_sw !== {32'h0000_0033, 1'b0, 2'b00}) begin
            $display("[TB] FAIL err_recover: got valid=%b err=%b data=%h required 1 0 %h",
                     b_valid_sw, b_err, b_data_sw, {32'h0000_0033, 1'b0, 2'b00});
        end else checks_passed++;
        tick();
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_only_req3();
        test_err_dest();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
